// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding req/gnt/rvalid memory handshake,
// registered output slot with one-entry skid buffer, and branch/jump redirect flush.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic [31:0] pend_pc;
    logic        sk_valid;
    logic [31:0] sk_instr;
    logic [31:0] sk_pc;

    logic        grant;
    logic        consume;
    logic        accept;
    logic        to_out;
    logic        to_skid;

    assign grant   = imem_req && imem_gnt;
    assign consume = if_valid && !stall;
    // A response that coincides with a redirect is stale and never captured.
    assign accept  = (state == S_WAIT) && imem_rvalid && !redirect_valid;
    assign to_out  = accept && !sk_valid && (!if_valid || consume);
    assign to_skid = accept && !to_out;

    assign imem_addr = fetch_pc;
    assign opcode    = if_instr[6:0];
    assign funct3    = if_instr[14:12];
    assign funct7    = if_instr[31:25];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_REQ: begin
                if (grant) begin
                    state_next = redirect_valid ? S_DRAIN : S_WAIT;
                end else begin
                    state_next = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_next = S_REQ;
                end else if (redirect_valid) begin
                    state_next = S_DRAIN;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_next = S_REQ;
                end else begin
                    state_next = S_DRAIN;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    // Requests are withheld while the skid is full so it can never overflow.
    always_comb begin
        imem_req = 1'b0;
        case (state)
            S_REQ:   imem_req = !sk_valid;
            S_WAIT:  imem_req = 1'b0;
            S_DRAIN: imem_req = 1'b0;
            default: imem_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            pend_pc  <= 32'h0000_0000;
            if_valid <= 1'b0;
            if_instr <= 32'h0000_0013;
            if_pc    <= 32'h0000_0000;
            sk_valid <= 1'b0;
            sk_instr <= 32'h0000_0013;
            sk_pc    <= 32'h0000_0000;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
            sk_valid <= 1'b0;
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (grant) begin
                pend_pc  <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (sk_valid && consume) begin
                if_valid <= 1'b1;
                if_instr <= sk_instr;
                if_pc    <= sk_pc;
                sk_valid <= 1'b0;
            end else if (to_out) begin
                if_valid <= 1'b1;
                if_instr <= imem_rdata;
                if_pc    <= pend_pc;
            end else if (consume) begin
                if_valid <= 1'b0;
            end
            if (to_skid) begin
                sk_valid <= 1'b1;
                sk_instr <= imem_rdata;
                sk_pc    <= pend_pc;
            end
        end
    end

endmodule
